// File: rtl/tdm_demux_8ch.sv
// tdm_demux_8ch: 8-slot time-division demultiplexer with a one-frame output stage.
// Serial slots are gathered into a shadow register; a completed frame is handed
// to a valid/ready output register, with overrun flagged when it cannot be taken.
module tdm_demux_8ch #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 sof,
  output logic [8*WIDTH-1:0]   q,
  output logic                 frame_valid,
  input  logic                 out_ready,
  output logic [2:0]           slot,
  output logic                 sync_err,
  output logic                 overrun
);

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                          state;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] shadow;

  logic                 start_c;
  logic                 resync_c;
  logic                 complete_c;
  logic                 pop_c;
  logic [8*WIDTH-1:0]   new_word_c;

  // Beat classification and the assembled word for the final slot
  always_comb begin
    start_c    = 1'b0;
    resync_c   = 1'b0;
    complete_c = 1'b0;
    pop_c      = frame_valid && out_ready;
    new_word_c = {din, shadow[NUM_SLOTS-2:0]};
    if (din_valid) begin
      if (sof) begin
        start_c  = 1'b1;
        resync_c = (state == COLLECT);
      end else if (state == COLLECT && slot == SLOT_W'(NUM_SLOTS - 1)) begin
        complete_c = 1'b1;
      end
    end
  end

  // Slot collection FSM and output stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      slot        <= '0;
      shadow      <= '0;
      q           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sync_err <= resync_c;

      // Collection side
      if (start_c) begin
        shadow[0] <= din;
        slot      <= SLOT_W'(1);
        state     <= COLLECT;
      end else if (complete_c) begin
        slot  <= '0;
        state <= IDLE;
      end else if (state == COLLECT && din_valid) begin
        shadow[slot] <= din;
        slot         <= slot + SLOT_W'(1);
      end

      // Output side: a load wins over a same-edge pop; otherwise a full stage drops
      if (complete_c && (!frame_valid || pop_c)) begin
        q           <= new_word_c;
        frame_valid <= 1'b1;
      end else if (complete_c) begin
        overrun <= 1'b1;
      end else if (pop_c) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Bench for tdm_demux_8ch: WIDTH=1 and WIDTH=4 instances share one stimulus
// stream (the 1-bit instance sees din[0]) and are compared to a queue-based model.
module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       resetn;
  logic       din_valid;
  logic       sof;
  logic       out_ready;
  logic [3:0] din;

  logic [7:0]  q1;
  logic [31:0] q4;
  logic        fv1, fv4, se1, se4, ov1, ov4;
  logic [2:0]  slot1, slot4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0]  m_col[$];
  logic        m_fv, m_se, m_ov;
  logic [31:0] m_q;

  always #5 clk = ~clk;

  tdm_demux_8ch #(.WIDTH(1)) u1 (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din[0:0]), .sof(sof),
    .q(q1), .frame_valid(fv1), .out_ready(out_ready), .slot(slot1),
    .sync_err(se1), .overrun(ov1)
  );

  tdm_demux_8ch #(.WIDTH(4)) u4 (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .sof(sof),
    .q(q4), .frame_valid(fv4), .out_ready(out_ready), .slot(slot4),
    .sync_err(se4), .overrun(ov4)
  );

  function automatic logic [7:0] low_bits(input logic [31:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[k*4];
    return r;
  endfunction

  function automatic logic [31:0] expand(input logic [7:0] b);
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = {3'b000, b[k]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col.delete();
    m_fv = 1'b0;
    m_se = 1'b0;
    m_ov = 1'b0;
    m_q  = '0;
  endtask

  // Frame-level rules applied to the beat presented at this edge
  task automatic model_edge();
    bit          pop  = m_fv && out_ready;
    bit          done = 1'b0;
    logic [31:0] w    = '0;
    m_se = 1'b0;
    if (din_valid) begin
      if (sof) begin
        if (m_col.size() > 0) m_se = 1'b1;
        m_col.delete();
        m_col.push_back(din);
      end else if (m_col.size() > 0) begin
        m_col.push_back(din);
        if (m_col.size() == 8) begin
          for (int k = 0; k < 8; k++) w[k*4 +: 4] = m_col[k];
          m_col.delete();
          done = 1'b1;
        end
      end
    end
    if (done && (!m_fv || pop)) begin
      m_q  = w;
      m_fv = 1'b1;
    end else if (done) begin
      m_ov = 1'b1;
    end else if (pop) begin
      m_fv = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] es = 3'(m_col.size());
    chk({tag, ".q4"},    q4,    m_q);
    chk({tag, ".q1"},    {24'd0, q1}, {24'd0, low_bits(m_q)});
    chk({tag, ".fv4"},   {31'd0, fv4}, {31'd0, m_fv});
    chk({tag, ".fv1"},   {31'd0, fv1}, {31'd0, m_fv});
    chk({tag, ".slot4"}, {29'd0, slot4}, {29'd0, es});
    chk({tag, ".slot1"}, {29'd0, slot1}, {29'd0, es});
    chk({tag, ".se4"},   {31'd0, se4}, {31'd0, m_se});
    chk({tag, ".se1"},   {31'd0, se1}, {31'd0, m_se});
    chk({tag, ".ov4"},   {31'd0, ov4}, {31'd0, m_ov});
    chk({tag, ".ov1"},   {31'd0, ov1}, {31'd0, m_ov});
  endtask

  task automatic step(input string tag, input logic v, input logic s,
                      input logic [3:0] d, input logic r);
    din_valid = v;
    sof       = s;
    din       = d;
    out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [31:0] w,
                            input logic r, input logic r_last);
    for (int k = 0; k < 8; k++)
      step(tag, 1'b1, k == 0, w[k*4 +: 4], (k == 7) ? r_last : r);
  endtask

  initial begin
    resetn = 1'b0; din_valid = 1'b0; sof = 1'b0; din = '0; out_ready = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    resetn = 1'b1;

    // 1: basic frame, slots 1,0,1,1,0,0,1,0
    send_frame("t1", expand(8'h4D), 1'b0, 1'b0);
    chk("t1_q1", {24'd0, q1}, 32'h4D);
    chk("t1_fv", {31'd0, fv1}, 32'd1);
    chk("t1_slot", {29'd0, slot1}, 32'd0);
    step("t1_pop", 1'b0, 1'b0, 4'd0, 1'b1);

    // 2: gaps inside the frame, then back-pressure and release
    for (int k = 0; k < 3; k++) step("t2a", 1'b1, k == 0, {3'b0, 1'(8'h4D >> k)}, 1'b0);
    for (int k = 0; k < 3; k++) step("t2gap", 1'b0, 1'b0, 4'hF, 1'b0);
    for (int k = 3; k < 8; k++) step("t2b", 1'b1, 1'b0, {3'b0, 1'(8'h4D >> k)}, 1'b0);
    for (int k = 0; k < 5; k++) step("t2hold", 1'b0, 1'b0, 4'd0, 1'b0);
    chk("t2_q1", {24'd0, q1}, 32'h4D);
    step("t2_pop", 1'b0, 1'b0, 4'd0, 1'b1);
    chk("t2_fv", {31'd0, fv1}, 32'd0);

    // 3: resync after 4 slots, then an all-ones frame
    for (int k = 0; k < 4; k++) step("t3part", 1'b1, k == 0, 4'd0, 1'b0);
    step("t3sof", 1'b1, 1'b1, 4'd1, 1'b0);
    chk("t3_se_on", {31'd0, se1}, 32'd1);
    step("t3s1", 1'b1, 1'b0, 4'd1, 1'b0);
    chk("t3_se_off", {31'd0, se1}, 32'd0);
    for (int k = 2; k < 8; k++) step("t3rest", 1'b1, 1'b0, 4'd1, 1'b0);
    chk("t3_q1", {24'd0, q1}, 32'hFF);
    chk("t3_ov", {31'd0, ov1}, 32'd0);
    step("t3_pop", 1'b0, 1'b0, 4'd0, 1'b1);

    // 4: overrun drop, then completion on a pop edge
    send_frame("t4a", expand(8'hA5), 1'b0, 1'b0);
    send_frame("t4b", expand(8'h3C), 1'b0, 1'b0);
    chk("t4_q_keep", {24'd0, q1}, 32'hA5);
    chk("t4_ov", {31'd0, ov1}, 32'd1);
    step("t4_pop", 1'b0, 1'b0, 4'd0, 1'b1);
    send_frame("t4c", expand(8'hA5), 1'b0, 1'b0);
    send_frame("t4d", expand(8'h3C), 1'b0, 1'b1);
    chk("t4_q_new", {24'd0, q1}, 32'h3C);
    chk("t4_fv", {31'd0, fv1}, 32'd1);
    step("t4_pop2", 1'b0, 1'b0, 4'd0, 1'b1);

    // 5: junk beats in IDLE, then asynchronous reset at slot 5
    for (int k = 0; k < 3; k++) step("t5junk", 1'b1, 1'b0, 4'(k + 3), 1'b1);
    chk("t5_slot", {29'd0, slot1}, 32'd0);
    for (int k = 0; k < 5; k++) step("t5part", 1'b1, k == 0, 4'(k), 1'b0);
    chk("t5_slot5", {29'd0, slot4}, 32'd5);
    din_valid = 1'b0;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("t5rst");
    @(posedge clk);
    #1;
    check_all("t5rst_hold");
    resetn = 1'b1;

    // 6: WIDTH=4 slot data 0..7
    send_frame("t6", 32'h7654_3210, 1'b0, 1'b0);
    chk("t6_q4", q4, 32'h7654_3210);
    chk("t6_q1", {24'd0, q1}, 32'hAA);
    step("t6_pop", 1'b0, 1'b0, 4'd0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
           4'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
